fetch_issue_unit: RTL and testbench

//  Upstream stage of the 8-bit CPU datapath. Holds a small loadable program memory and a

---
 rtl/cpu8_pkg.sv | 78 +++++++
 rtl/cpu8_regfile.sv | 49 ++++
 rtl/fetch_issue_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_issue_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// -----------------------------------------------------------------------------
// cpu8_pkg
//   Shared definitions for the 8-bit CPU front end: data/register widths,
//   ALU opcode values, 16-bit instruction field positions, the reserved HALT
//   encoding, the fetch/issue FSM state encoding and a small decode helper.
//
//   Instruction layout (16 bits):
//     [15:13] opcode | [12] imm | [11:10] rd | [9:8] ra | [7:0] imm8
//     When imm = 0 the second source register rb sits in [1:0].
// -----------------------------------------------------------------------------
package cpu8_pkg;

  // Datapath geometry
  localparam int IW       = 16;  // instruction width
  localparam int DW       = 8;   // data / register width
  localparam int RF_DEPTH = 4;   // architectural registers
  localparam int RF_AW    = 2;   // register address width

  // ALU operation select values carried on the opcode output
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  // Instruction field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int IMM_BIT  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 10;
  localparam int RA_MSB   = 9;
  localparam int RA_LSB   = 8;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;
  localparam int RB_MSB   = 1;
  localparam int RB_LSB   = 0;

  // Reserved encoding: stops the machine, never issued downstream
  localparam logic [IW-1:0] HALT_WORD = 16'hFFFF;

  // Fetch/issue sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_WB,
    HALT
  } state_t;

  // Decoded instruction fields
  typedef struct packed {
    logic [2:0]       opcode;
    logic             imm;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] ra;
    logic [DW-1:0]    imm8;
  } instr_t;

  function automatic instr_t decode(input logic [IW-1:0] w);
    instr_t d;
    d.opcode = w[OPC_MSB:OPC_LSB];
    d.imm    = w[IMM_BIT];
    d.rd     = w[RD_MSB:RD_LSB];
    d.ra     = w[RA_MSB:RA_LSB];
    d.imm8   = w[IMM8_MSB:IMM8_LSB];
    return d;
  endfunction

  // rb shares bit positions with the low end of imm8
  function automatic logic [RF_AW-1:0] rb_of(input instr_t d);
    return d.imm8[RB_MSB:RB_LSB];
  endfunction

endpackage

// File: rtl/cpu8_regfile.sv
// -----------------------------------------------------------------------------
// cpu8_regfile
//   4 x 8-bit architectural register file with two asynchronous read ports
//   and one synchronous write port. All registers clear on reset.
//
//   Ports
//     clk      in   clock, writes on rising edge
//     rst      in   synchronous active-high reset, clears every register
//     we       in   write enable
//     wr_addr  in   write address
//     wr_data  in   write data
//     ra_addr  in   read port A address
//     ra_data  out  read port A data (combinational)
//     rb_addr  in   read port B address
//     rb_data  out  read port B data (combinational)
// -----------------------------------------------------------------------------
module cpu8_regfile
  import cpu8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RF_AW-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [RF_AW-1:0] ra_addr,
  output logic [DW-1:0]    ra_data,
  input  logic [RF_AW-1:0] rb_addr,
  output logic [DW-1:0]    rb_data
);

  logic [DW-1:0] regs [RF_DEPTH];

  // NOTE: state registers are written with <= so every flop samples the
  // pre-edge value of its inputs; blocking = here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/fetch_issue_unit.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit
//   Upstream stage of the 8-bit CPU. Holds a loadable program memory and the
//   program counter, fetches one 16-bit instruction at a time, reads its
//   operands from the register file and offers {opcode, a, b} downstream over
//   a valid/ready handshake. After the handshake it waits for the downstream
//   result pulse, writes it back and only then fetches the next instruction,
//   so operand reads never need a bypass path.
//
//   Sequencer:  IDLE/HALT --start--> FETCH -> ISSUE --handshake--> WAIT_WB
//               WAIT_WB --wb_valid--> FETCH (pc+1);  ISSUE --HALT_WORD--> HALT
//
//   Ports
//     clk          in   clock, all state updates on rising edge
//     rst          in   synchronous active-high reset
//     start        in   begin execution at pc 0 (IDLE/HALT only)
//     prog_we      in   program memory write strobe (IDLE/HALT only)
//     prog_addr    in   program memory write address
//     prog_wdata   in   program memory write data
//     issue_valid  out  {opcode, a, b} valid this cycle
//     issue_ready  in   downstream accepts; handshake = valid & ready
//     opcode       out  ALU operation select
//     a            out  operand A = rf[ra]
//     b            out  operand B = imm ? imm8 : rf[rb]
//     wb_valid     in   downstream result valid (single-cycle pulse)
//     wb_data      in   result written to rf[rd]
//     wb_carry     in   carry from the ALU
//     carry_flag   out  carry of the last written-back instruction
//     pc           out  current program counter
//     busy         out  high in FETCH/ISSUE/WAIT_WB
//     halted       out  high in HALT
// -----------------------------------------------------------------------------
module fetch_issue_unit
  import cpu8_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  localparam int PW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [IW-1:0] prog_wdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [2:0]    opcode,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  input  logic          wb_valid,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_carry,
  output logic          carry_flag,
  output logic [PW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  state_t         state_q;
  state_t         state_d;
  logic [IW-1:0]  prog_mem [PROG_DEPTH];
  logic [IW-1:0]  instr_q;
  logic [PW-1:0]  pc_q;
  logic           carry_q;

  instr_t         dec;
  logic [DW-1:0]  rf_a;
  logic [DW-1:0]  rf_b;
  logic           stopped;   // IDLE or HALT: the only states that accept start/prog_we
  logic           is_halt;
  logic           wb_fire;

  assign dec     = decode(instr_q);
  assign stopped = (state_q == IDLE) || (state_q == HALT);
  assign is_halt = (instr_q == HALT_WORD);
  assign wb_fire = (state_q == WAIT_WB) && wb_valid;

  // ---------------------------------------------------------------------------
  // Program memory: written only while stopped, read synchronously in FETCH.
  // A write and a start in the same IDLE cycle land before FETCH reads, so
  // the new word is fetched when it targets address 0.
  // ---------------------------------------------------------------------------
  // NOTE: the program array deliberately has no reset branch; clearing a
  // memory on reset prevents RAM inference and the loaded program must
  // survive a reset anyway.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && stopped) begin
      prog_mem[prog_addr] <= prog_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: the writeback port is the only writer, active in WAIT_WB
  // ---------------------------------------------------------------------------
  cpu8_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_fire),
    .wr_addr (dec.rd),
    .wr_data (wb_data),
    .ra_addr (dec.ra),
    .ra_data (rf_a),
    .rb_addr (rb_of(dec)),
    .rb_data (rf_b)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter, instruction register and carry flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      carry_q <= 1'b0;
    end else begin
      if (stopped && start) begin
        pc_q <= '0;
      end else if (wb_fire) begin
        pc_q <= pc_q + 1'b1;  // wraps naturally at PROG_DEPTH
      end

      if (state_q == FETCH) begin
        instr_q <= prog_mem[pc_q];
      end

      if (wb_fire) begin
        carry_q <= wb_carry;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and issue outputs. instr_q only changes in FETCH and the
  // register file only changes in WAIT_WB, so opcode/a/b are stable for the
  // whole ISSUE stall. Outside an issue they are held at zero.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    issue_valid = 1'b0;
    opcode      = '0;
    a           = '0;
    b           = '0;

    unique case (state_q)
      IDLE, HALT: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        if (is_halt) begin
          state_d = HALT;
        end else begin
          issue_valid = 1'b1;
          opcode      = dec.opcode;
          a           = rf_a;
          b           = dec.imm ? dec.imm8 : rf_b;
          if (issue_ready) state_d = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (wb_valid) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign carry_flag = carry_q;
  assign pc         = pc_q;
  assign busy       = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT_WB);
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_issue_unit
//   Self-checking bench for fetch_issue_unit. The bench plays the downstream
//   ALU stage. Expected values come from an instruction-level model: a copy of
//   the program, four register values, a carry bit and a pc, advanced once per
//   executed instruction.
// -----------------------------------------------------------------------------
module tb_fetch_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        wb_valid;
  logic [7:0]  wb_data;
  logic        wb_carry;
  logic        carry_flag;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;

  always #5 clk = ~clk;

  fetch_issue_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_carry    (wb_carry),
    .carry_flag  (carry_flag),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction-level reference model
  logic [15:0] mmem [16];
  logic [7:0]  mrf  [4];
  logic        mcarry;
  logic [3:0]  mpc;

  typedef struct {
    logic       start;
    logic       ready;
    logic       wbv;
    logic [7:0] wbd;
    logic       wbc;
    logic       iv;
    logic [2:0] op;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] epc;
    logic       ebusy;
    logic       ehalt;
    logic       ecarry;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    mcarry = 1'b0;
    mpc    = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; issue_ready = 1'b0; wb_valid = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load(input int addr, input logic [15:0] word);
    prog_we = 1'b1; prog_addr = 4'(addr); prog_wdata = word;
    tick();
    prog_we = 1'b0;
    mmem[addr] = word;
  endtask

  // Runs the loaded program from pc 0 (optionally pulsing start first), acting
  // as the downstream stage. wb_mode: 0 random result, 1 add of operands,
  // 2 zero result with carry set. bp_fixed < 0 selects random backpressure.
  task automatic run_prog(input bit do_start, input int max_instr, input int bp_fixed,
                          input int wb_mode, input bit noise);
    logic [15:0] w;
    logic [7:0]  ea, eb, d;
    logic [8:0]  sum;
    logic        c;
    int          bp, dly;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    mpc = 4'd0;
    check("fetch_busy", 32'(busy), 32'd1);
    for (int n = 0; n < max_instr; n++) begin
      w = mmem[mpc];
      tick();
      if (w == 16'hFFFF) begin
        check("halt_not_issued", 32'(issue_valid), 32'd0);
        tick();
        check("halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_pc", 32'(pc), 32'(mpc));
        check("halt_carry", 32'(carry_flag), 32'(mcarry));
        return;
      end
      ea = mrf[w[9:8]];
      eb = w[12] ? w[7:0] : mrf[w[1:0]];
      bp = (bp_fixed >= 0) ? bp_fixed : int'($urandom_range(0, 3));
      for (int k = 0; k <= bp; k++) begin
        check("issue_valid", 32'(issue_valid), 32'd1);
        check("opcode", 32'(opcode), 32'(w[15:13]));
        check("a", 32'(a), 32'(ea));
        check("b", 32'(b), 32'(eb));
        check("issue_pc", 32'(pc), 32'(mpc));
        check("issue_carry", 32'(carry_flag), 32'(mcarry));
        if (k < bp) begin
          issue_ready = 1'b0;
          if (noise) begin
            wb_valid   = 1'($urandom_range(0, 1));
            wb_data    = 8'($urandom);
            wb_carry   = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            prog_we    = 1'($urandom_range(0, 1));
            prog_addr  = 4'($urandom);
            prog_wdata = 16'($urandom);
          end
          tick();
          wb_valid = 1'b0; start = 1'b0; prog_we = 1'b0;
        end
      end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("issue_drop", 32'(issue_valid), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      dly = int'($urandom_range(0, 3));
      for (int k = 0; k < dly; k++) begin
        if (noise) begin
          start      = 1'($urandom_range(0, 1));
          prog_we    = 1'($urandom_range(0, 1));
          prog_addr  = 4'($urandom);
          prog_wdata = 16'($urandom);
        end
        tick();
        start = 1'b0; prog_we = 1'b0;
        check("wait_no_issue", 32'(issue_valid), 32'd0);
        check("wait_pc", 32'(pc), 32'(mpc));
      end
      case (wb_mode)
        0: begin d = 8'($urandom_range(1, 255)); c = 1'($urandom_range(0, 1)); end
        1: begin sum = ea + eb; d = sum[7:0]; c = sum[8]; end
        default: begin d = 8'h00; c = 1'b1; end
      endcase
      wb_valid = 1'b1; wb_data = d; wb_carry = c;
      tick();
      wb_valid = 1'b0;
      mrf[w[11:10]] = d;
      mcarry = c;
      mpc = mpc + 4'd1;
      check("wb_pc", 32'(pc), 32'(mpc));
      check("wb_carry", 32'(carry_flag), 32'(mcarry));
      check("wb_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    int          halt_at;

    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    issue_ready = 1'b0; wb_valid = 1'b0; wb_data = '0; wb_carry = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();

    // Reset state
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_b", 32'(b), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);

    // Cycle-by-cycle table: r0=r0+5, r1=r0+r0, HALT, then restart from HALT
    //                start rdy wbv wbd    wbc  iv  op    a      b      pc     busy halt carry
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 8'h05, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h05, 8'h05, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd2, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd2, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h05, 8'h05, 4'd0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      load(i, (i == 0) ? 16'h1005 : (i == 1) ? 16'h0400 : 16'hFFFF);
    end
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; issue_ready = vecs[i].ready;
      wb_valid = vecs[i].wbv; wb_data = vecs[i].wbd; wb_carry = vecs[i].wbc;
      tick();
      check($sformatf("vec%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].iv));
      if (vecs[i].iv) begin
        check($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
        check($sformatf("vec%0d_a", i), 32'(a), 32'(vecs[i].ea));
        check($sformatf("vec%0d_b", i), 32'(b), 32'(vecs[i].eb));
      end
      check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].epc));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].ehalt));
      check($sformatf("vec%0d_carry", i), 32'(carry_flag), 32'(vecs[i].ecarry));
    end
    start = 1'b0; issue_ready = 1'b0; wb_valid = 1'b0;
    do_reset();

    // Carry: ADD writes 0 with carry 1, carry survives HALT and restart
    load(0, 16'h1000);
    load(1, 16'hFFFF);
    run_prog(1'b1, 4, 0, 2, 1'b0);
    run_prog(1'b1, 4, 0, 0, 1'b0);

    // Backpressure: five stalled cycles in ISSUE, then one handshake
    load(0, 16'h5E42);
    load(1, 16'h2B01);
    load(2, 16'hFFFF);
    run_prog(1'b1, 4, 5, 0, 1'b0);

    // pc wrap: sixteen r0=r0+1, executed 18 times
    do_reset();
    for (int i = 0; i < 16; i++) load(i, 16'h1001);
    run_prog(1'b1, 18, 0, 1, 1'b0);
    do_reset();

    // Program that reads all four registers; first fill them
    load(0, 16'h0001);
    load(1, 16'h0623);
    load(2, 16'h0B00);
    load(3, 16'h0F01);
    load(4, 16'hFFFF);
    run_prog(1'b1, 6, -1, 0, 1'b0);

    // Reset in WAIT_WB, with an ignored program write beforehand and an
    // ignored writeback afterwards
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midop_issue", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("midop_wait_busy", 32'(busy), 32'd1);
    prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 16'h0000;
    tick();
    prog_we = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop_rst_issue_valid", 32'(issue_valid), 32'd0);
    check("midop_rst_pc", 32'(pc), 32'd0);
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_halted", 32'(halted), 32'd0);
    check("midop_rst_carry", 32'(carry_flag), 32'd0);
    wb_valid = 1'b1; wb_data = 8'hAA; wb_carry = 1'b1;
    tick();
    wb_valid = 1'b0;
    check("idle_wb_pc", 32'(pc), 32'd0);
    check("idle_wb_busy", 32'(busy), 32'd0);
    check("idle_wb_carry", 32'(carry_flag), 32'd0);
    model_reset();
    run_prog(1'b1, 6, -1, 0, 1'b0);

    // Program write and start in the same stopped cycle
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'h1E77; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    mmem[0] = 16'h1E77;
    run_prog(1'b0, 6, -1, 0, 1'b0);

    // Random programs with noise on ignored inputs
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) begin
        w = 16'($urandom);
        if (w == 16'hFFFF) w = 16'h0000;
        load(i, w);
      end
      halt_at = int'($urandom_range(1, 15));
      load(halt_at, 16'hFFFF);
      run_prog(1'b1, 20, -1, int'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
